// File: rtl/bldc_pkg.sv
// Shared types and constants for the six-step BLDC commutation controller.
// Leg requests are encoded Z/H/L; the forward table packs {A,B,C} legs per hall code.
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LEG_Z = 2'd0,
        LEG_H = 2'd1,
        LEG_L = 2'd2
    } leg_t;

    localparam logic [2:0] HALL_INV0 = 3'd0;
    localparam logic [2:0] HALL_INV7 = 3'd7;

    // Entry [code] = {A[5:4], B[3:2], C[1:0]}; codes 0 and 7 request all legs Z.
    localparam logic [7:0][5:0] FWD_TABLE = {
        6'b00_00_00,  // 7
        6'b00_01_10,  // 6: Z,H,L
        6'b01_10_00,  // 5: H,L,Z
        6'b01_00_10,  // 4: H,Z,L
        6'b10_00_01,  // 3: L,Z,H
        6'b10_01_00,  // 2: L,H,Z
        6'b00_10_01,  // 1: Z,L,H
        6'b00_00_00   // 0
    };

    function automatic leg_t leg_swap(input leg_t l);
        case (l)
            LEG_H:   return LEG_L;
            LEG_L:   return LEG_H;
            default: return LEG_Z;
        endcase
    endfunction

endpackage

// File: rtl/bldc_deadtime_leg.sv
// One half-bridge leg: turns a Z/H/L request plus pwm into hi/lo gates.
// A gate may only turn on once its complement has been off for DEAD_CYC cycles.
module bldc_deadtime_leg
    import bldc_pkg::*;
#(
    parameter int unsigned DEAD_CYC = 50
) (
    input  logic clk,
    input  logic rst,
    input  leg_t req,
    input  logic pwm,
    output logic hi,
    output logic lo
);

    localparam int unsigned CW = $clog2(DEAD_CYC + 1);

    logic [CW-1:0] hi_off;
    logic [CW-1:0] lo_off;
    logic          hi_d;
    logic          lo_d;

    // Off-counters track the registered gate value, so they count the cycle just committed.
    always_comb begin
        hi_d = (req == LEG_H) && pwm && (lo_off == CW'(DEAD_CYC));
        lo_d = (req == LEG_L) && (hi_off == CW'(DEAD_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= 1'b0;
            lo     <= 1'b0;
            hi_off <= '0;
            lo_off <= '0;
        end else begin
            hi <= hi_d;
            lo <= lo_d;
            if (hi_d)
                hi_off <= '0;
            else if (hi_off != CW'(DEAD_CYC))
                hi_off <= hi_off + CW'(1);
            if (lo_d)
                lo_off <= '0;
            else if (lo_off != CW'(DEAD_CYC))
                lo_off <= lo_off + CW'(1);
        end
    end

endmodule

// File: rtl/bldc_six_step_ctrl.sv
// Hall-sensor six-step commutation controller: hall sync/filter, PWM, state machine,
// stall detection, and per-leg dead-time gate drive.
module bldc_six_step_ctrl
    import bldc_pkg::*;
#(
    parameter int unsigned PWM_W     = 16,
    parameter int unsigned FILT_CYC  = 8,
    parameter int unsigned DEAD_CYC  = 50,
    parameter int unsigned STALL_W   = 26,
    parameter int unsigned STALL_CYC = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             brake,
    input  logic             fault_clr,
    input  logic [PWM_W-1:0] period,
    input  logic [PWM_W-1:0] duty,
    input  logic             hallA,
    input  logic             hallB,
    input  logic             hallC,
    output logic [2:0]       gate_hi,
    output logic [2:0]       gate_lo,
    output logic [2:0]       hall_code,
    output logic             commut,
    output logic             fault,
    output logic [1:0]       state
);

    localparam int unsigned FILT_W = $clog2(FILT_CYC + 1);

    state_t             state_q, state_d;
    logic [2:0]         sync1, sync2, cand, hall_q;
    logic [FILT_W-1:0]  filt_cnt, filt_nxt;
    logic               accept;
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;
    logic               hall_valid;
    logic [PWM_W-1:0]   cnt, period_sh, duty_sh;
    logic               wrap, leave_idle, pwm;
    leg_t               req [3];

    // Stability count restarts at 1 whenever the synchronised code moves.
    always_comb begin
        if (sync2 != cand)
            filt_nxt = FILT_W'(1);
        else if (filt_cnt == FILT_W'(FILT_CYC))
            filt_nxt = filt_cnt;
        else
            filt_nxt = filt_cnt + FILT_W'(1);
        accept = (filt_nxt == FILT_W'(FILT_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            filt_cnt <= '0;
            hall_q   <= '0;
            commut   <= 1'b0;
        end else begin
            sync1    <= {hallA, hallB, hallC};
            sync2    <= sync1;
            cand     <= sync2;
            filt_cnt <= filt_nxt;
            commut   <= accept && (sync2 != hall_q);
            if (accept)
                hall_q <= sync2;
        end
    end

    assign hall_valid = (hall_q != HALL_INV0) && (hall_q != HALL_INV7);
    assign stall_hit  = (stall_cnt >= STALL_W'(STALL_CYC));

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_RUN || commut)
            stall_cnt <= '0;
        else if (stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (brake)
                    state_d = ST_BRAKE;
                else if (en && hall_valid)
                    state_d = ST_RUN;
            ST_RUN:
                if (!hall_valid || stall_hit)
                    state_d = ST_FAULT;
                else if (brake)
                    state_d = ST_BRAKE;
                else if (!en)
                    state_d = ST_IDLE;
            ST_BRAKE:
                if (!brake)
                    state_d = ST_IDLE;
            default:
                if (fault_clr && !en)
                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // A zero period is treated as wrapping every cycle so new settings still load.
    assign wrap       = (period_sh == '0) || (cnt == period_sh - PWM_W'(1));
    assign leave_idle = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    assign pwm        = (period_sh == '0) ? (duty_sh != '0) : (cnt < duty_sh);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (wrap || leave_idle) begin
            cnt       <= '0;
            period_sh <= period;
            duty_sh   <= duty;
        end else begin
            cnt <= cnt + PWM_W'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            req[i] = LEG_Z;
            case (state_q)
                ST_RUN: begin
                    req[i] = leg_t'(FWD_TABLE[hall_q][2*i +: 2]);
                    if (dir)
                        req[i] = leg_swap(req[i]);
                end
                ST_BRAKE: req[i] = LEG_L;
                default:  req[i] = LEG_Z;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        bldc_deadtime_leg #(.DEAD_CYC(DEAD_CYC)) u_leg (
            .clk (clk),
            .rst (rst),
            .req (req[g]),
            .pwm (pwm),
            .hi  (gate_hi[g]),
            .lo  (gate_lo[g])
        );
    end

    assign hall_code = hall_q;
    assign fault     = (state_q == ST_FAULT);
    assign state     = state_q;

endmodule

// File: tb/tb_bldc_six_step_ctrl.sv
// Self-checking bench for bldc_six_step_ctrl against a table-driven model of the
// commutation rules, filter latency, PWM duty, dead time and fault/brake behaviour.
module tb_bldc_six_step_ctrl;

    localparam int FILT  = 8;
    localparam int DEAD  = 20;
    localparam int STALL = 1000;

    logic        clk = 1'b0;
    logic        rst, en, dir, brake, fault_clr;
    logic [15:0] period, duty;
    logic        hallA, hallB, hallC;
    logic [2:0]  gate_hi, gate_lo, hall_code;
    logic        commut, fault;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    int last_on [3];
    int zrun [3];
    int cur_code;

    string tbl [8] = '{"ZZZ", "ZLH", "LHZ", "LZH", "HZL", "HLZ", "ZHL", "ZZZ"};

    bldc_six_step_ctrl #(
        .PWM_W    (16),
        .FILT_CYC (FILT),
        .DEAD_CYC (DEAD),
        .STALL_W  (26),
        .STALL_CYC(STALL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .brake(brake), .fault_clr(fault_clr),
        .period(period), .duty(duty), .hallA(hallA), .hallB(hallB), .hallC(hallC),
        .gate_hi(gate_hi), .gate_lo(gate_lo), .hall_code(hall_code),
        .commut(commut), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // Model: leg drive letter for phase ph (0=A,1=B,2=C) in RUN.
    function automatic byte exp_leg(input int code, input logic d, input int ph);
        string s;
        byte   c;
        s = tbl[code];
        c = s[ph];
        if (d && c == "H") c = "L";
        else if (d && c == "L") c = "H";
        return c;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hall(input int code);
        logic [2:0] c;
        c = code[2:0];
        {hallA, hallB, hallC} = c;
        cur_code = code;
    endtask

    // Per-leg overlap and dead-time monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (gate_hi[i] === 1'b1 && gate_lo[i] === 1'b1) begin
                    n_err++;
                    $display("FAIL overlap leg%0d: hi=%b lo=%b, required not both 1", i, gate_hi[i], gate_lo[i]);
                end
                if (gate_lo[i] === 1'b1 && last_on[i] == 1) begin
                    n_cmp++;
                    if (zrun[i] < DEAD) begin
                        n_err++;
                        $display("FAIL deadtime_hl leg%0d: gap=%0d, required >= %0d", i, zrun[i], DEAD);
                    end
                end
                if (gate_hi[i] === 1'b1 && last_on[i] == 2) begin
                    n_cmp++;
                    if (zrun[i] < DEAD) begin
                        n_err++;
                        $display("FAIL deadtime_lh leg%0d: gap=%0d, required >= %0d", i, zrun[i], DEAD);
                    end
                end
                if (gate_hi[i] === 1'b1) begin
                    last_on[i] = 1;
                    zrun[i] = 0;
                end else if (gate_lo[i] === 1'b1) begin
                    last_on[i] = 2;
                    zrun[i] = 0;
                end else begin
                    zrun[i]++;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; dir = 1'b0; brake = 1'b0; fault_clr = 1'b0;
        period = 16'd100; duty = 16'd25;
        set_hall(0);
        step(3);
        n_cmp++; if (gate_hi !== 3'b000) begin n_err++; $display("FAIL reset_gate_hi: got %b, required 000", gate_hi); end
        n_cmp++; if (gate_lo !== 3'b000) begin n_err++; $display("FAIL reset_gate_lo: got %b, required 000", gate_lo); end
        n_cmp++; if (hall_code !== 3'd0) begin n_err++; $display("FAIL reset_hall_code: got %0d, required 0", hall_code); end
        n_cmp++; if (commut !== 1'b0) begin n_err++; $display("FAIL reset_commut: got %b, required 0", commut); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b, required 0", fault); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d, required 0", state); end
        for (int i = 0; i < 3; i++) begin last_on[i] = 0; zrun[i] = 0; end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_enter_run;
        int got;
        got = 0;
        set_hall(1);
        en = 1'b1;
        for (int c = 0; c < 40 && got == 0; c++) begin
            step(1);
            if (state === 2'd1) got = 1;
        end
        n_cmp++;
        if (got != 1) begin n_err++; $display("FAIL enter_run: state=%0d, required 1 within 40 cycles", state); end
    endtask

    task automatic test_sequence(input logic d);
        int seq [6] = '{5, 4, 6, 2, 3, 1};
        int lat, hcnt, lo_bad, hi_bad;
        logic [2:0] exp_lo, hi_mask;
        dir = d;
        for (int k = 0; k < 6; k++) begin
            set_hall(seq[k]);
            lat = -1;
            for (int c = 1; c <= 40 && lat < 0; c++) begin
                step(1);
                if (commut === 1'b1) lat = c;
            end
            n_cmp++;
            if (lat != 2 + FILT) begin n_err++; $display("FAIL commut_latency dir=%0d code=%0d: got %0d, required %0d", d, seq[k], lat, 2 + FILT); end
            n_cmp++;
            if (hall_code !== 3'(seq[k])) begin n_err++; $display("FAIL hall_code dir=%0d: got %0d, required %0d", d, hall_code, seq[k]); end
            step(300 - (lat < 0 ? 40 : lat));
            exp_lo = 3'b000; hi_mask = 3'b000;
            for (int ph = 0; ph < 3; ph++) begin
                if (exp_leg(seq[k], d, ph) == "L") exp_lo[2-ph] = 1'b1;
                if (exp_leg(seq[k], d, ph) == "H") hi_mask[2-ph] = 1'b1;
            end
            hcnt = 0; lo_bad = 0; hi_bad = 0;
            for (int c = 0; c < 100; c++) begin
                step(1);
                if (gate_lo !== exp_lo) lo_bad++;
                if ((gate_hi & ~hi_mask) !== 3'b000) hi_bad++;
                if ((gate_hi & hi_mask) !== 3'b000) hcnt++;
            end
            n_cmp++;
            if (lo_bad != 0) begin n_err++; $display("FAIL lo_pattern dir=%0d code=%0d: got %b in %0d cycles, required %b", d, seq[k], gate_lo, lo_bad, exp_lo); end
            n_cmp++;
            if (hi_bad != 0) begin n_err++; $display("FAIL hi_pattern dir=%0d code=%0d: got %b in %0d cycles, required within %b", d, seq[k], gate_hi, hi_bad, hi_mask); end
            n_cmp++;
            if (hcnt != 25) begin n_err++; $display("FAIL hi_duty dir=%0d code=%0d: got %0d/100, required 25/100", d, seq[k], hcnt); end
            step(100);
        end
    endtask

    task automatic test_glitch;
        int seen;
        set_hall(5);
        step(2 + FILT + 2);
        step(50);
        n_cmp++;
        if (hall_code !== 3'd5) begin n_err++; $display("FAIL glitch_pre: hall_code=%0d, required 5", hall_code); end
        set_hall(1);
        step(3);
        set_hall(5);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (commut === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL glitch_commut: got %0d pulses, required 0", seen); end
        n_cmp++;
        if (hall_code !== 3'd5) begin n_err++; $display("FAIL glitch_hall_code: got %0d, required 5", hall_code); end
    endtask

    task automatic test_invalid;
        set_hall(7);
        step(20);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL invalid_state: got %0d, required 3", state); end
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL invalid_fault: got %b, required 1", fault); end
        n_cmp++; if (gate_hi !== 3'b000 || gate_lo !== 3'b000) begin n_err++; $display("FAIL invalid_gates: got hi=%b lo=%b, required 000/000", gate_hi, gate_lo); end
        set_hall(5);
        fault_clr = 1'b1;
        step(5);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL clr_with_en: state=%0d, required 3", state); end
        en = 1'b0;
        step(2);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL clr_without_en: state=%0d, required 0", state); end
        fault_clr = 1'b0;
    endtask

    task automatic test_stall;
        int got, k;
        set_hall(3);
        en = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            step(1);
            if (commut === 1'b1) got = 1;
        end
        n_cmp++;
        if (got != 1) begin n_err++; $display("FAIL stall_commut: no commut within 40 cycles, required one"); end
        k = -1;
        for (int c = 1; c <= STALL + 50 && k < 0; c++) begin
            step(1);
            if (state === 2'd3) k = c;
        end
        n_cmp++;
        if (k < STALL || k > STALL + 3) begin n_err++; $display("FAIL stall_time: fault after %0d cycles, required %0d..%0d", k, STALL, STALL + 3); end
        en = 1'b0;
        fault_clr = 1'b1;
        step(2);
        fault_clr = 1'b0;
        n_cmp++;
        if (state !== 2'd0) begin n_err++; $display("FAIL stall_recover: state=%0d, required 0", state); end
    endtask

    task automatic test_brake;
        set_hall(5);
        step(15);
        en = 1'b1;
        step(300);
        brake = 1'b1;
        step(2);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL brake_state: got %0d, required 2", state); end
        n_cmp++; if (gate_hi !== 3'b000) begin n_err++; $display("FAIL brake_hi: got %b, required 000", gate_hi); end
        step(DEAD + 4);
        n_cmp++; if (gate_lo !== 3'b111) begin n_err++; $display("FAIL brake_lo: got %b, required 111", gate_lo); end
        brake = 1'b0;
        step(1);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL brake_release: state=%0d, required 0", state); end
    endtask

    task automatic test_random_pwm;
        int p, du, code, hcnt, lo_bad, hexp;
        logic d;
        logic [2:0] exp_lo, hi_mask;
        for (int it = 0; it < 6; it++) begin
            p  = $urandom_range(150, 20);
            du = $urandom_range(p + 20, 0);
            code = $urandom_range(6, 1);
            if (code == cur_code) code = (code % 6) + 1;
            d = 1'($urandom_range(1, 0));
            period = 16'(p); duty = 16'(du); dir = d;
            set_hall(code);
            step(350);
            n_cmp++;
            if (state !== 2'd1) begin n_err++; $display("FAIL rand_state it=%0d: got %0d, required 1", it, state); end
            exp_lo = 3'b000; hi_mask = 3'b000;
            for (int ph = 0; ph < 3; ph++) begin
                if (exp_leg(code, d, ph) == "L") exp_lo[2-ph] = 1'b1;
                if (exp_leg(code, d, ph) == "H") hi_mask[2-ph] = 1'b1;
            end
            hexp = (du >= p) ? p : du;
            hcnt = 0; lo_bad = 0;
            for (int c = 0; c < p; c++) begin
                step(1);
                if (gate_lo !== exp_lo) lo_bad++;
                if ((gate_hi & hi_mask) !== 3'b000) hcnt++;
            end
            n_cmp++;
            if (lo_bad != 0) begin n_err++; $display("FAIL rand_lo it=%0d code=%0d dir=%0d: got %b, required %b", it, code, d, gate_lo, exp_lo); end
            n_cmp++;
            if (hcnt != hexp) begin n_err++; $display("FAIL rand_duty it=%0d p=%0d d=%0d: got %0d, required %0d", it, p, du, hcnt, hexp); end
        end
    endtask

    task automatic test_reset_midrun;
        rst = 1'b1;
        step(1);
        n_cmp++; if (gate_hi !== 3'b000 || gate_lo !== 3'b000) begin n_err++; $display("FAIL midrun_reset_gates: got hi=%b lo=%b, required 000/000", gate_hi, gate_lo); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL midrun_reset_state: got %0d, required 0", state); end
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_enter_run();
        test_sequence(1'b0);
        test_sequence(1'b1);
        test_glitch();
        test_invalid();
        test_stall();
        test_brake();
        test_random_pwm();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
